// File: rtl/spi_responder_regfile_pkg.sv
// Shared types and constants for the SPI responder register file.
// Latency: n/a. Backpressure: n/a.
// Holds the frame-state encoding and the pin synchronizer depth.
package spi_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int SYNC_STAGES = 2;

    function automatic int frame_bits(input int addr_width, input int data_width);
        return addr_width + data_width;
    endfunction

endpackage

// File: rtl/spi_responder_regfile_pin_sync.sv
// Synchronizes sclk/ss/mosi into clk and produces single-cycle edge pulses.
// Latency: SYNC_STAGES clk to the synced level, edge pulse acted on one clk later.
// Backpressure: none; the pins are free-running.
module spi_pin_sync
    import spi_resp_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic ss,
    input  logic mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic ss_rise,
    output logic ss_fall,
    output logic mosi_s
);

    // {sclk, ss, mosi}; select resets deasserted so reset release never fakes a frame start
    localparam logic [2:0] PIN_RST = 3'b010;

    logic [2:0] sync_q [SYNC_STAGES];
    logic [2:0] cur;
    logic [1:0] prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= PIN_RST;
            prev_q <= PIN_RST[2:1];
        end else begin
            sync_q[0] <= {sclk, ss, mosi};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= sync_q[SYNC_STAGES-1][2:1];
        end
    end

    assign cur       = sync_q[SYNC_STAGES-1];
    assign sclk_rise =  cur[2] & ~prev_q[1];
    assign sclk_fall = ~cur[2] &  prev_q[1];
    assign ss_rise   =  cur[1] & ~prev_q[0];
    assign ss_fall   = ~cur[1] &  prev_q[0];
    assign mosi_s    =  cur[0];

endmodule

// File: rtl/spi_responder_regfile.sv
// SPI target with a small register file: 16-bit command then 16-bit data per frame.
// Latency: SPI write commits 3 clk after the last sample-edge pin transition; host read is 1 clk.
// Backpressure: none; SPI commit wins the single write port over a same-clk host write.
module spi_responder_regfile
    import spi_resp_pkg::*;
#(
    parameter int ADDR_WIDTH       = 16,
    parameter int DATA_WIDTH       = 16,
    parameter int REG_AW           = 4,
    parameter int SCK_RISING_SHIFT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  ss,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [REG_AW-1:0]     host_addr,
    input  logic                  host_we,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  wr_stb,
    output logic [REG_AW-1:0]     wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  frame_err
);

    localparam int FRAME_BITS = frame_bits(ADDR_WIDTH, DATA_WIDTH);
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam int NREG       = 1 << REG_AW;

    logic sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_s;
    logic sample_edge, shift_edge;

    spi_pin_sync u_pin_sync (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .ss        (ss),
        .mosi      (mosi),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .ss_rise   (ss_rise),
        .ss_fall   (ss_fall),
        .mosi_s    (mosi_s)
    );

    assign sample_edge = (SCK_RISING_SHIFT != 0) ? sclk_fall : sclk_rise;
    assign shift_edge  = (SCK_RISING_SHIFT != 0) ? sclk_rise : sclk_fall;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      bit_cnt;
    // Only the address bits are kept; ignored command bits fall off the top.
    logic [REG_AW-1:0]     cmd_sr;
    logic [REG_AW-1:0]     addr_next;
    logic [DATA_WIDTH-1:0] rx_sr, rx_word, tx_sr;
    logic                  rd_flag;
    logic [REG_AW-1:0]     reg_addr;
    logic [DATA_WIDTH-1:0] regfile [NREG];
    logic                  cmd_done, data_done, commit;

    assign addr_next = {cmd_sr[REG_AW-2:0], mosi_s};
    assign rx_word   = {rx_sr[DATA_WIDTH-2:0], mosi_s};
    assign commit    = data_done & ~rd_flag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_done  = 1'b0;
        data_done = 1'b0;
        if (ss_rise) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (ss_fall) state_nxt = CMD;
                CMD: if (sample_edge && bit_cnt == CNT_W'(ADDR_WIDTH-1)) begin
                    cmd_done  = 1'b1;
                    state_nxt = DATA;
                end
                DATA: if (sample_edge && bit_cnt == CNT_W'(DATA_WIDTH-1)) begin
                    data_done = 1'b1;
                    state_nxt = DONE;
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regfile[i] <= '0;
            host_rdata <= '0;
        end else begin
            host_rdata <= regfile[host_addr];
            if (commit)       regfile[reg_addr]  <= rx_word;
            else if (host_we) regfile[host_addr] <= host_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= '0;
            cmd_sr    <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            rd_flag   <= 1'b0;
            reg_addr  <= '0;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
            wr_stb    <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
        end else begin
            wr_stb    <= 1'b0;
            frame_err <= 1'b0;
            if (commit) begin
                wr_stb  <= 1'b1;
                wr_addr <= reg_addr;
                wr_data <= rx_word;
            end
            if (ss_rise) begin
                miso_oe   <= 1'b0;
                frame_err <= (state == CMD) || (state == DATA);
            end else begin
                case (state)
                    IDLE: if (ss_fall) begin
                        bit_cnt <= '0;
                        miso    <= 1'b0;
                    end
                    CMD: if (sample_edge) begin
                        cmd_sr <= addr_next;
                        if (bit_cnt == '0) rd_flag <= mosi_s;
                        bit_cnt <= cmd_done ? '0 : bit_cnt + 1'b1;
                        if (cmd_done) begin
                            reg_addr <= addr_next;
                            tx_sr    <= regfile[addr_next];
                            miso_oe  <= rd_flag;
                        end
                    end
                    DATA: begin
                        if (sample_edge) begin
                            rx_sr   <= rx_word;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                        if (data_done) miso_oe <= 1'b0;
                        if (rd_flag && shift_edge) begin
                            miso  <= tx_sr[DATA_WIDTH-1];
                            tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/spi_responder_regfile.md
Name: spi_responder_regfile

Overview:
- SPI target (slave) end of the command/data protocol our SPI master drives: 16-bit command word (MSB = read flag, low bits = register address) followed by a 16-bit data word.
- Holds a small register file that an external SPI master writes and reads back. Serves as a stand-in device for the AMC7823 link and as an FPGA-side target when another controller owns the bus.
- The SPI pins are oversampled in the system clock domain. There is no second clock.

Parameters:
- ADDR_WIDTH, 16, command word length in bits. Bit ADDR_WIDTH-1 is the read flag (1 = read).
- DATA_WIDTH, 16, data word length in bits.
- REG_AW, 4, register file address bits, taken from command bits [REG_AW-1:0]. Command bits [ADDR_WIDTH-2:REG_AW] are ignored.
- SCK_RISING_SHIFT, 1, matches the master setting. 1: the master shifts on rising sclk, this block samples mosi on falling sclk and updates miso on rising sclk. 0: edges swapped.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- sclk  in  1  SPI clock from the master, asynchronous.
- ss  in  1  SPI select, active low, asynchronous.
- mosi  in  1  serial data from the master.
- miso  out  1  serial data to the master.
- miso_oe  out  1  high while driving miso during the data phase of a read.
- host_addr  in  REG_AW  local read/write address.
- host_we  in  1  local write strobe.
- host_wdata  in  DATA_WIDTH  local write data.
- host_rdata  out  DATA_WIDTH  registered read: regfile[host_addr] one clk later.
- wr_stb  out  1  one-cycle pulse when an SPI write commits.
- wr_addr  out  REG_AW  address of the last SPI write.
- wr_data  out  DATA_WIDTH  data of the last SPI write.
- frame_err  out  1  one-cycle pulse on a short frame.

Behaviour:
- Reset applies asynchronously on rst high. Every output is 0. Regfile is cleared to 0. State is IDLE and the bit counter is 0.
- sclk, ss and mosi each pass through a 2-FF synchronizer. Edges are detected on the synced sclk, so the sample point is 3 clk after the pin edge. A legal master sclk half period is at least 4 clk (our master uses 16).
- States: IDLE, CMD, DATA, DONE.
  - IDLE: synced ss falling moves to CMD, clears the bit counter, and sets miso=0.
  - CMD: on each sample edge, shift mosi into cmd_sr (MSB first) and increment the counter. When the counter reaches ADDR_WIDTH, latch rd_flag and reg_addr, snapshot regfile[reg_addr] into tx_sr, and go to DATA.
  - DATA, read: miso_oe=1. On each shift edge, miso <= tx_sr MSB and tx_sr shifts left. The first shift edge after CMD drives the data MSB.
  - DATA, write: shift mosi into rx_sr on sample edges. When DATA_WIDTH bits are received, write regfile[reg_addr] and pulse wr_stb on the next clk with wr_addr/wr_data updated. Then go to DONE.
  - DATA, read completion: after DATA_WIDTH bits, go to DONE. No write occurs.
  - DONE: ignore further sclk edges. miso_oe=0.
- Synced ss rising in any state returns to IDLE and drops miso_oe the same clk. If the state was CMD or DATA (fewer than ADDR_WIDTH+DATA_WIDTH bits), frame_err pulses one clk and nothing is written.
- Read data is the value snapshotted at the end of the command phase. A host write during the data phase does not change the bits being shifted out.
- Write collision: if the SPI commit and host_we occur in the same clk, the SPI write wins. The host write is dropped, even when the addresses differ, because the regfile has a single write port. host_rdata reflects the committed value on the following read.
- Sclk edges while ss is high are ignored.
- mosi is valid only in CMD and DATA. miso holds its last value when miso_oe=0.

Decomposition:
- Shared package spi_resp_pkg:
  - state enum (IDLE, CMD, DATA, DONE);
  - synchronizer depth constant SYNC_STAGES=2;
  - derived FRAME_BITS = ADDR_WIDTH + DATA_WIDTH.
- One sub-module, spi_pin_sync: 2-FF synchronizers plus sclk rise/fall edge pulses and ss rise/fall pulses.

Test Plan:
- Write, then read back. Master frame cmd 0x0003, data 0xA5C3. Expect:
  - wr_stb pulses once with wr_addr=3, wr_data=0xA5C3;
  - a host read of addr 3 returns 0xA5C3;
  - a following frame cmd 0x8003 shifts 0xA5C3 on miso MSB first, with miso_oe high only during the 16 data bits.
- Host preload. Host writes 0x1234 to addr 7, then SPI reads 0x8007. Master receives 0x1234, and wr_stb stays 0.
- Short frame. ss rises after 20 bits of a write to addr 2 (data 0xFFFF). Expect frame_err pulse, no wr_stb, and regfile[2] unchanged at 0.
- Collision:
  - an SPI write to addr 1 with 0xBEEF commits in the same clk as host_we to addr 1 with 0x0001 → regfile[1]=0xBEEF;
  - repeat with host_we addr 4 → regfile[4] remains 0 and regfile[1] updated.
- Snapshot isolation. During the data phase of a read of addr 5 (value 0x00FF), host writes 0xFF00 to addr 5. Master receives 0x00FF, and a subsequent read returns 0xFF00.
- Reset mid-frame. Assert rst after 10 command bits: all outputs go to 0 immediately. The next full write frame (cmd 0x0006, data 0x5555) commits normally.
